// File: rtl/rr_packet_selector.sv
// Round-robin, packet-locked arbiter that muxes in_val requesters onto one registered output channel.
// Latency: 1 cycle from in_valid to sel, then 1 cycle from input beat transfer to out/out_valid.
// Backpressure: in_ready follows the granted sel and opens only when the output register is empty or draining.
module rr_packet_selector #(
    parameter int in_size = 2,
    parameter int in_val  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [in_size*in_val-1:0] in,
    input  logic [in_val-1:0]         in_valid,
    input  logic [in_val-1:0]         in_last,
    output logic [in_val-1:0]         in_ready,
    output logic [in_val-1:0]         sel,
    output logic [in_size-1:0]        out,
    output logic                      out_valid,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic                      busy
);

    localparam int pw = (in_val > 1) ? $clog2(in_val) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state, state_n;
    logic [in_val-1:0]   sel_n;
    logic [pw-1:0]       ptr, ptr_n;
    logic [in_val-1:0]   rot_valid;
    logic [pw-1:0]       off, pick, g;
    logic [pw:0]         pick_sum, g_sum;
    logic [in_size-1:0]  sel_dat;
    logic                sel_last;
    logic                out_open;
    logic                in_xfer;

    assign out_open = !out_valid || out_ready;
    assign in_ready = (state == BUSY && !rst) ? (sel & {in_val{out_open}}) : '0;
    assign in_xfer  = |(in_valid & in_ready);
    assign busy     = (state == BUSY);

    // Rotate requests so bit 0 is the requester at ptr; the lowest set bit wins.
    assign rot_valid = in_val'({in_valid, in_valid} >> ptr);

    always_comb begin
        off = '0;
        for (int k = in_val - 1; k >= 0; k--) begin
            if (rot_valid[k]) off = pw'(k);
        end
        pick_sum = {1'b0, ptr} + {1'b0, off};
        pick     = (pick_sum >= (pw+1)'(in_val)) ? pw'(pick_sum - (pw+1)'(in_val)) : pw'(pick_sum);
    end

    // One-hot AND-OR datapath plus encoded index of the current grant.
    always_comb begin
        g       = '0;
        sel_dat = '0;
        for (int i = 0; i < in_val; i++) begin
            if (sel[i]) g = pw'(i);
            sel_dat = sel_dat | (in[i*in_size +: in_size] & {in_size{sel[i]}});
        end
        sel_last = |(in_last & sel);
        g_sum    = {1'b0, g} + (pw+1)'(1);
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        ptr_n   = ptr;
        case (state)
            IDLE: begin
                if (|in_valid) begin
                    state_n = BUSY;
                    sel_n   = in_val'(1) << pick;
                end
            end
            BUSY: begin
                if (in_xfer && sel_last) begin
                    state_n = IDLE;
                    sel_n   = '0;
                    ptr_n   = (g_sum >= (pw+1)'(in_val)) ? '0 : pw'(g_sum);
                end
            end
            default: begin
                state_n = IDLE;
                sel_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            ptr   <= ptr_n;
        end
    end

    // Load and drain may coincide, giving one beat per cycle while streaming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (in_xfer) begin
            out       <= sel_dat;
            out_last  <= sel_last;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    sel_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(sel));

endmodule
